// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: imem request/response channel plus the decode-facing instruction handshake.
// master = sequencer side, slave = memory/decode side.
interface pc_fetch_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer for the RV32 core.
// Handles redirects (with kill of in-flight fetches), misaligned-target traps and halt.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pc_fetch_sequencer_if.master        bus,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_target,
    input  logic                        halt,
    output logic [31:0]                 pc,
    output logic                        misaligned_trap,
    output logic [31:0]                 bad_addr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RSP = 3'd2,
        HOLD     = 3'd3,
        HALTED   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        kill_q, kill_d;
    logic        trap_q, trap_d;
    logic [31:0] bad_addr_q, bad_addr_d;

    logic        redir;
    logic        hs;
    state_e      resume_state;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        kill_d       = kill_q;
        trap_d       = 1'b0;
        bad_addr_d   = bad_addr_q;

        redir        = redirect_valid && (state_q != IDLE);
        hs           = (state_q == REQ) && bus.imem_req_ready;
        resume_state = halt ? HALTED : REQ;

        // Redirect owns the PC in every active state; a misaligned target traps instead.
        if (redir) begin
            if (redirect_target[1:0] == 2'b00) begin
                pc_d = redirect_target;
            end else begin
                pc_d       = TRAP_VECTOR;
                trap_d     = 1'b1;
                bad_addr_d = redirect_target;
            end
        end

        unique case (state_q)
            IDLE: state_d = resume_state;
            REQ: begin
                if (hs) begin
                    state_d = WAIT_RSP;
                    kill_d  = redir;
                end else if (halt) begin
                    state_d = HALTED;
                end
            end
            WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    if (kill_q || redir) begin
                        kill_d  = 1'b0;
                        state_d = resume_state;
                    end else begin
                        inst_d       = bus.imem_rsp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                // A same-cycle consume and redirect retires the instruction but the redirect sets the PC.
                if (redir || bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = resume_state;
                    if (!redir) pc_d = pc_q + 32'd4;
                end
            end
            HALTED: begin
                if (!halt) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            kill_q       <= 1'b0;
            trap_q       <= 1'b0;
            bad_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            kill_q       <= kill_d;
            trap_q       <= trap_d;
            bad_addr_q   <= bad_addr_d;
        end
    end

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign pc                 = pc_q;
    assign misaligned_trap    = trap_q;
    assign bad_addr           = bad_addr_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus a randomized run checked against an
// architectural PC model (next retired PC = previous + 4, or redirect target / trap vector).
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] pc, bad_addr;
    logic        misaligned_trap;

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt(halt),
        .pc(pc), .misaligned_trap(misaligned_trap), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // imem responder state (one outstanding request)
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          rsp_delay = 1;
    logic        force_en = 1'b0;
    logic [31:0] force_data = 32'h0;

    // what happened at the edge crossed by the last step()
    logic        obs_hs, obs_cons;
    logic [31:0] obs_hs_addr, obs_cons_pc, obs_cons_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic step();
        obs_hs        = bus.imem_req_valid && bus.imem_req_ready;
        obs_hs_addr   = bus.imem_req_addr;
        obs_cons      = bus.inst_valid && bus.inst_ready;
        obs_cons_pc   = bus.inst_pc;
        obs_cons_inst = bus.inst;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
        if (obs_hs) begin
            pend_addr = obs_hs_addr;
            pend_cnt  = rsp_delay;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = force_en ? force_data : mem_word(pend_addr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (pc !== RV) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, RV); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b exp 0", bus.imem_req_valid); end
        checks++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid got %b exp 0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst got %h/%h exp 0/0", bus.inst, bus.inst_pc); end
        checks++; if (misaligned_trap !== 1'b0 || bad_addr !== 32'h0) begin fails++; $display("FAIL reset_trap got %b/%h exp 0/0", misaligned_trap, bad_addr); end
        rst_n = 1'b1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL idle_req_valid got %b exp 0", bus.imem_req_valid); end
        step();
        checks++; if (bus.imem_req_valid !== 1'b1) begin fails++; $display("FAIL first_req_valid got %b exp 1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== RV) begin fails++; $display("FAIL first_req_addr got %h exp %h", bus.imem_req_addr, RV); end
    endtask

    task automatic test_sequential();
        int n = 0;
        int last = 0;
        logic [31:0] exp = RV;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        rsp_delay          = 1;
        step();
        checks++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL seq_wait_valid got %b exp 0", bus.inst_valid); end
        step();
        checks++; if (bus.inst_valid !== 1'b1) begin fails++; $display("FAIL seq_latency got %b exp 1", bus.inst_valid); end
        for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
            step();
            if (obs_cons) begin
                checks++; if (obs_cons_pc !== exp) begin fails++; $display("FAIL seq_inst_pc got %h exp %h", obs_cons_pc, exp); end
                checks++; if (obs_cons_inst !== mem_word(exp)) begin fails++; $display("FAIL seq_inst got %h exp %h", obs_cons_inst, mem_word(exp)); end
                if (n > 0) begin
                    checks++; if (cyc - last !== 3) begin fails++; $display("FAIL seq_throughput got %0d exp 3", cyc - last); end
                end
                last = cyc;
                exp += 32'd4;
                n++;
            end
        end
        checks++; if (n !== 3) begin fails++; $display("FAIL seq_count got %0d exp 3", n); end
    endtask

    task automatic test_wrap();
        logic got = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_redirect_pc got %h exp fffffffc", pc); end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (obs_cons) begin
                got = 1'b1;
                checks++; if (obs_cons_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_inst_pc got %h exp fffffffc", obs_cons_pc); end
                checks++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h exp 00000000", pc); end
            end
        end
        checks++; if (!got) begin fails++; $display("FAIL wrap_timeout got none exp consume"); end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (obs_hs) begin
                got = 1'b1;
                checks++; if (obs_hs_addr !== 32'h0) begin fails++; $display("FAIL wrap_req_addr got %h exp 00000000", obs_hs_addr); end
            end
        end
        checks++; if (!got) begin fails++; $display("FAIL wrap_req_timeout got none exp request"); end
    endtask

    task automatic test_redirect_wait();
        logic got = 1'b0;
        logic seen = 1'b0;
        rsp_delay = 4;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = obs_hs;
        end
        checks++; if (!got) begin fails++; $display("FAIL rw_req_timeout got none exp request"); end
        force_en        = 1'b1;
        force_data      = 32'hDEAD_BEEF;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_00C0;
        step();
        redirect_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (bus.inst_valid) seen = 1'b1;
            if (obs_hs) begin
                got = 1'b1;
                checks++; if (obs_hs_addr !== 32'h0000_00C0) begin fails++; $display("FAIL rw_req_addr got %h exp 000000c0", obs_hs_addr); end
            end
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rw_killed_valid got %b exp 0", seen); end
        checks++; if (!got) begin fails++; $display("FAIL rw_refetch_timeout got none exp request"); end
        force_en  = 1'b0;
        rsp_delay = 1;
    endtask

    task automatic test_misaligned();
        logic got = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FED1;
        step();
        redirect_valid = 1'b0;
        checks++; if (misaligned_trap !== 1'b1) begin fails++; $display("FAIL mis_trap got %b exp 1", misaligned_trap); end
        checks++; if (bad_addr !== 32'hFFFF_FED1) begin fails++; $display("FAIL mis_bad_addr got %h exp fffffed1", bad_addr); end
        checks++; if (pc !== TV) begin fails++; $display("FAIL mis_pc got %h exp %h", pc, TV); end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (i == 0) begin
                checks++; if (misaligned_trap !== 1'b0) begin fails++; $display("FAIL mis_pulse got %b exp 0", misaligned_trap); end
                checks++; if (bad_addr !== 32'hFFFF_FED1) begin fails++; $display("FAIL mis_bad_hold got %h exp fffffed1", bad_addr); end
            end
            if (obs_hs) begin
                got = 1'b1;
                checks++; if (obs_hs_addr !== TV) begin fails++; $display("FAIL mis_req_addr got %h exp %h", obs_hs_addr, TV); end
            end
        end
        checks++; if (!got) begin fails++; $display("FAIL mis_req_timeout got none exp request"); end
    endtask

    task automatic test_halt_hold();
        logic [31:0] h_inst, h_pc;
        int i = 0;
        bus.inst_ready = 1'b0;
        while (!bus.inst_valid && i < 20) begin
            step();
            i++;
        end
        checks++; if (bus.inst_valid !== 1'b1) begin fails++; $display("FAIL hh_valid_timeout got %b exp 1", bus.inst_valid); end
        h_inst = bus.inst;
        h_pc   = bus.inst_pc;
        halt   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== h_inst || bus.inst_pc !== h_pc) begin
                fails++; $display("FAIL hh_stable got %b/%h/%h exp 1/%h/%h", bus.inst_valid, bus.inst, bus.inst_pc, h_inst, h_pc);
            end
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            fails++; $display("FAIL hh_halted got %b/%b exp 0/0", bus.inst_valid, bus.imem_req_valid);
        end
        checks++; if (pc !== h_pc + 32'd4) begin fails++; $display("FAIL hh_pc got %h exp %h", pc, h_pc + 32'd4); end
        step();
        step();
        checks++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL hh_stay_halted got %b exp 0", bus.imem_req_valid); end
        halt = 1'b0;
        step();
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== h_pc + 32'd4) begin
            fails++; $display("FAIL hh_resume got %b/%h exp 1/%h", bus.imem_req_valid, bus.imem_req_addr, h_pc + 32'd4);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = RV;
        logic [31:0] exp_bad = 32'h0;
        logic        exp_trap;
        logic [31:0] t;
        int          ndeliv = 0;
        // reset lands while a fetch response may still be pending; it must be ignored
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b1;
        step();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.inst_ready     = $urandom_range(0, 1) == 1;
            rsp_delay          = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 11) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            redirect_target = t;
            step();
            if (obs_cons) begin
                ndeliv++;
                checks++; if (obs_cons_pc !== exp_pc) begin fails++; $display("FAIL rnd_inst_pc cyc %0d got %h exp %h", cyc, obs_cons_pc, exp_pc); end
                checks++; if (obs_cons_inst !== mem_word(obs_cons_pc)) begin fails++; $display("FAIL rnd_inst cyc %0d got %h exp %h", cyc, obs_cons_inst, mem_word(obs_cons_pc)); end
            end
            if (obs_hs) begin
                checks++; if (obs_hs_addr !== exp_pc) begin fails++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, obs_hs_addr, exp_pc); end
            end
            exp_trap = 1'b0;
            if (redirect_valid) begin
                if (redirect_target[1:0] == 2'b00) begin
                    exp_pc = redirect_target;
                end else begin
                    exp_pc   = TV;
                    exp_trap = 1'b1;
                    exp_bad  = redirect_target;
                end
            end else if (obs_cons) begin
                exp_pc = exp_pc + 32'd4;
            end
            checks++; if (pc !== exp_pc) begin fails++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, pc, exp_pc); end
            checks++; if (misaligned_trap !== exp_trap || bad_addr !== exp_bad) begin
                fails++; $display("FAIL rnd_trap cyc %0d got %b/%h exp %b/%h", cyc, misaligned_trap, bad_addr, exp_trap, exp_bad);
            end
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
        checks++; if (ndeliv < 10) begin fails++; $display("FAIL rnd_progress got %0d exp >=10", ndeliv); end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b0;
        test_reset();
        test_sequential();
        test_wrap();
        test_redirect_wait();
        test_misaligned();
        test_halt_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end
endmodule
